riot_gen2: RTL and testbench
============================

Name: riot_gen2

Overview:
- Second-generation Wishbone 6532-style RIOT peripheral for the Atari 2600 core.
- Adds a prescaled interval timer with real underflow behaviour: the timer flag is set, the counter wraps, and it then counts at the 1T rate.
- Also adds bidirectional ports A/B with data-direction registers, PA7 edge detection, and a maskable interrupt output.
- Sits on the CPU-side Wishbone bus beside the TIA; joystick/console switches connect to the port inputs.

Parameters:
- CLK_DIV, 24: system clocks per CPU cycle (one timer tick). Must be ≥ 2.
- PA_DDR_RST, 8'h00: port A direction reset value (1 = output).
- PB_DDR_RST, 8'h00: port B direction reset value.
- PB_OUT_RST, 8'h00: port B output-register reset value.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- stb_i  in  1  Wishbone strobe
- we_i  in  1  write enable
- adr_i  in  7  register address
- dat_i  in  8  write data
- ack_o  out  1  acknowledge
- dat_o  out  8  read data
- pa_i  in  8  port A pin levels
- pa_o  out  8  port A output register
- pa_oe  out  8  port A direction (1 = drive)
- pb_i  in  8  port B pin levels
- pb_o  out  8  port B output register
- pb_oe  out  8  port B direction
- irq_o  out  1  interrupt, active high

Behaviour:
- Reset (rst_i high at a clock edge):
  - ack_o=0, dat_o=0, irq_o=0.
  - pa_o=0, pa_oe=PA_DDR_RST, pb_o=PB_OUT_RST, pb_oe=PB_DDR_RST.
  - INTIM=0, interval=1T, prescaler=0, all flags cleared, both interrupt enables 0, edge polarity falling.
- Bus handshake:
  - ack_o is registered: ack_o <= stb_i & ~rst_i, so latency is one cycle.
  - dat_o updates on the same edge as ack_o and holds between reads.
  - Side effects fire on every clock where stb_i is high.
- Reads, decoded on adr_i[4:0] (upper bits ignored):
  - 0 SWCHA = (pa_o & pa_oe) | (pa_i & ~pa_oe).
  - 1 SWACNT = pa_oe.
  - 2 SWCHB = same mix for port B.
  - 3 SWBCNT = pb_oe.
  - 4 or 0x0C INTIM: returns the counter and clears the timer flag.
  - 5 or 0x0D INSTAT: {timer_flag, pa7_flag, 6'b0}; clears pa7_flag.
  - Others read 0.
- Writes:
  - 0/1/2/3 load pa_o / pa_oe / pb_o / pb_oe.
  - 0x04-0x07: edge polarity = adr_i[0] (1 = rising); PA7 interrupt enable = adr_i[1].
  - 0x14-0x17 (interrupt enable 0) and 0x1C-0x1F (interrupt enable 1): load INTIM=dat_i, select interval 1/8/64/1024 by adr_i[1:0], clear prescaler, clear timer flag, leave underflow mode.
- Tick generation: the prescaler counts 0..CLK_DIV-1 and emits a one-clock tick at CLK_DIV-1.
- Interval counter (11 bits): counts ticks. When it reaches interval-1 on a tick it returns to 0 and INTIM decrements.
- Underflow: a decrement from 0 sets INTIM=8'hFF, sets timer_flag and enters 1T mode, so INTIM then decrements on every tick. 1T mode persists until the next timer write.
- Simultaneous events:
  - A timer write beats a same-cycle decrement.
  - A flag set beats a same-cycle read-clear, for both flags.
  - A timer write in the same cycle as an underflow leaves the flag cleared.
- PA7 edge detection:
  - The effective PA7 (port-mix bit 7) passes through a 2-flop synchroniser.
  - A transition matching the polarity sets pa7_flag.
  - Writing a new polarity does not by itself set the flag.
- Interrupt: irq_o is registered = (timer_flag & tim_ie) | (pa7_flag & pa7_ie).
- Reset mid-operation aborts any timer count and bus cycle. No ack is issued for a strobe during reset.

Decomposition:
- Package riot_pkg:
  - register offset localparams (SWCHA..INSTAT, TIM1T..T1024T, IE bit position 3);
  - interval constants 1/8/64/1024;
  - INSTAT bit positions.
- Sub-module riot_timer: prescaler, interval counter, INTIM, underflow/1T mode, timer_flag.
  - Inputs: load strobe, load value, interval select, read-clear.
  - Outputs: intim, flag.
- Bus decode, ports, edge detect and irq stay in riot_gen2.

Test Plan:
- Reset, then read addresses 0-5 with pa_i=8'hA5, pb_i=8'h3C, DDRs 0 → reads A5, 00, 3C, 00, 00, 00; every ack_o arrives exactly one cycle after stb_i.
- Write SWACNT=F0, SWCHA=5A, pa_i=0F → SWCHA reads 5F; pa_oe=F0, pa_o=5A.
- With CLK_DIV=24, write 0x15 (TIM8T) with data 03 → INTIM reads 03, 02, 01, 00 at 192-clock steps; at clock 768 it reads FF with INSTAT bit7 set; it then decrements every 24 clocks; irq_o stays 0.
- Write 0x1E (TIM64T, IE) with data 00 → after 64 ticks INTIM=FF, irq_o=1; reading INTIM drops irq_o next cycle and INTIM keeps decrementing per tick.
- Write 0x07 (rising edge, IE), then drive pa_i[7] 0→1 → irq_o rises within 4 clocks; INSTAT read returns 8'h40 then 8'h00; a 1→0 transition sets nothing.
- Write 0x14 with data 05 on the exact clock of a scheduled decrement → INTIM=05 and the prescaler restarts; a read-clear coinciding with underflow leaves timer_flag=1.

Source files
------------

// File: rtl/riot_pkg.sv
// Shared constants for the riot_gen2 RIOT peripheral: register offsets,
// address decode masks, timer interval lengths and INSTAT bit positions.
package riot_pkg;

  localparam logic [4:0] ADR_SWCHA      = 5'h00;
  localparam logic [4:0] ADR_SWACNT     = 5'h01;
  localparam logic [4:0] ADR_SWCHB      = 5'h02;
  localparam logic [4:0] ADR_SWBCNT     = 5'h03;
  localparam logic [4:0] ADR_INTIM      = 5'h04;
  localparam logic [4:0] ADR_INSTAT     = 5'h05;
  localparam logic [4:0] ADR_INTIM_ALT  = 5'h0C;
  localparam logic [4:0] ADR_INSTAT_ALT = 5'h0D;

  // Edge control lives at 0x04-0x07, timer loads at 0x14-0x17 / 0x1C-0x1F.
  localparam logic [4:0] ADR_EDGE_BASE = 5'h04;
  localparam logic [4:0] EDGE_ADR_MASK = 5'h1C;
  localparam logic [4:0] ADR_TIM1T     = 5'h14;
  localparam logic [4:0] TIM_ADR_MASK  = 5'h14;
  localparam int         ADR_IE_BIT    = 3;

  localparam logic [10:0] IVL_1T    = 11'd1;
  localparam logic [10:0] IVL_8T    = 11'd8;
  localparam logic [10:0] IVL_64T   = 11'd64;
  localparam logic [10:0] IVL_1024T = 11'd1024;

  localparam int INSTAT_TIM_BIT = 7;
  localparam int INSTAT_PA7_BIT = 6;

  function automatic logic [10:0] interval_len(input logic [1:0] sel);
    case (sel)
      2'd0:    return IVL_1T;
      2'd1:    return IVL_8T;
      2'd2:    return IVL_64T;
      default: return IVL_1024T;
    endcase
  endfunction

endpackage

// File: rtl/riot_timer.sv
// Prescaled interval timer: CPU-cycle prescaler, interval counter, INTIM,
// underflow into 1T mode and the sticky timer flag.
module riot_timer
  import riot_pkg::*;
#(
  parameter int CLK_DIV = 24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic [1:0] sel_i,
  input  logic       rd_clr_i,
  output logic [7:0] intim_o,
  output logic       flag_o
);

  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic [10:0]   ivl_cnt_q, ivl_cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          one_t_q, one_t_d;
  logic [7:0]    intim_q, intim_d;
  logic          flag_q, flag_d;
  logic          tick;
  logic          dec;

  always_comb begin
    tick      = (presc_q == PW'(CLK_DIV - 1));
    presc_d   = tick ? '0 : presc_q + 1'b1;
    ivl_cnt_d = ivl_cnt_q;
    sel_d     = sel_q;
    one_t_d   = one_t_q;
    intim_d   = intim_q;
    flag_d    = flag_q & ~rd_clr_i;
    dec       = 1'b0;

    if (tick) begin
      if (one_t_q || (ivl_cnt_q == interval_len(sel_q) - 11'd1)) begin
        ivl_cnt_d = '0;
        dec       = 1'b1;
      end else begin
        ivl_cnt_d = ivl_cnt_q + 11'd1;
      end
    end

    // Decrement from zero wraps to FF, so the flag set happens here and
    // overrides a same-cycle read-clear.
    if (dec) begin
      intim_d = intim_q - 8'd1;
      if (intim_q == 8'd0) begin
        flag_d  = 1'b1;
        one_t_d = 1'b1;
      end
    end

    // A load wins over any decrement or underflow in the same cycle.
    if (load_i) begin
      intim_d   = load_val_i;
      sel_d     = sel_i;
      presc_d   = '0;
      ivl_cnt_d = '0;
      flag_d    = 1'b0;
      one_t_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      ivl_cnt_q <= '0;
      sel_q     <= 2'd0;
      one_t_q   <= 1'b0;
      intim_q   <= 8'd0;
      flag_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      ivl_cnt_q <= ivl_cnt_d;
      sel_q     <= sel_d;
      one_t_q   <= one_t_d;
      intim_q   <= intim_d;
      flag_q    <= flag_d;
    end
  end

  assign intim_o = intim_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/riot_gen2.sv
// Wishbone 6532-style RIOT: ports A/B with direction registers, PA7 edge
// detect, interval timer and a maskable interrupt.
module riot_gen2
  import riot_pkg::*;
#(
  parameter int         CLK_DIV    = 24,
  parameter logic [7:0] PA_DDR_RST = 8'h00,
  parameter logic [7:0] PB_DDR_RST = 8'h00,
  parameter logic [7:0] PB_OUT_RST = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [6:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       ack_o,
  output logic [7:0] dat_o,
  input  logic [7:0] pa_i,
  output logic [7:0] pa_o,
  output logic [7:0] pa_oe,
  input  logic [7:0] pb_i,
  output logic [7:0] pb_o,
  output logic [7:0] pb_oe,
  output logic       irq_o
);

  logic       ack_q, ack_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] pa_o_q, pa_o_d, pa_oe_q, pa_oe_d;
  logic [7:0] pb_o_q, pb_o_d, pb_oe_q, pb_oe_d;
  logic       pol_q, pol_d;
  logic       pa7_ie_q, pa7_ie_d;
  logic       tim_ie_q, tim_ie_d;
  logic       sync1_q, sync2_q, last_q;
  logic       pa7_flag_q, pa7_flag_d;
  logic       irq_q, irq_d;

  logic [4:0] adr;
  logic [7:0] pa_mix, pb_mix, rd_data, intim;
  logic       rd, wr, tim_load, tim_rd_clr, pa7_rd_clr, pa7_edge, tim_flag;
  logic       unused_adr;

  assign adr        = adr_i[4:0];
  assign unused_adr = ^adr_i[6:5];

  always_comb begin
    pa_mix     = (pa_o_q & pa_oe_q) | (pa_i & ~pa_oe_q);
    pb_mix     = (pb_o_q & pb_oe_q) | (pb_i & ~pb_oe_q);
    rd         = stb_i & ~we_i;
    wr         = stb_i & we_i;
    tim_load   = wr && ((adr & TIM_ADR_MASK) == ADR_TIM1T);
    tim_rd_clr = rd && ((adr == ADR_INTIM) || (adr == ADR_INTIM_ALT));
    pa7_rd_clr = rd && ((adr == ADR_INSTAT) || (adr == ADR_INSTAT_ALT));
    pa7_edge   = pol_q ? (sync2_q & ~last_q) : (~sync2_q & last_q);

    rd_data = 8'h00;
    case (adr)
      ADR_SWCHA:  rd_data = pa_mix;
      ADR_SWACNT: rd_data = pa_oe_q;
      ADR_SWCHB:  rd_data = pb_mix;
      ADR_SWBCNT: rd_data = pb_oe_q;
      ADR_INTIM, ADR_INTIM_ALT: rd_data = intim;
      ADR_INSTAT, ADR_INSTAT_ALT: begin
        rd_data[INSTAT_TIM_BIT] = tim_flag;
        rd_data[INSTAT_PA7_BIT] = pa7_flag_q;
      end
      default: rd_data = 8'h00;
    endcase

    ack_d    = stb_i;
    dat_d    = rd ? rd_data : dat_q;
    pa_o_d   = (wr && adr == ADR_SWCHA)  ? dat_i : pa_o_q;
    pa_oe_d  = (wr && adr == ADR_SWACNT) ? dat_i : pa_oe_q;
    pb_o_d   = (wr && adr == ADR_SWCHB)  ? dat_i : pb_o_q;
    pb_oe_d  = (wr && adr == ADR_SWBCNT) ? dat_i : pb_oe_q;
    pol_d    = pol_q;
    pa7_ie_d = pa7_ie_q;
    if (wr && ((adr & EDGE_ADR_MASK) == ADR_EDGE_BASE)) begin
      pol_d    = adr[0];
      pa7_ie_d = adr[1];
    end
    tim_ie_d   = tim_load ? adr[ADR_IE_BIT] : tim_ie_q;
    pa7_flag_d = pa7_edge | (pa7_flag_q & ~pa7_rd_clr);
    irq_d      = (tim_flag & tim_ie_q) | (pa7_flag_q & pa7_ie_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= 8'h00;
      pa_o_q     <= 8'h00;
      pa_oe_q    <= PA_DDR_RST;
      pb_o_q     <= PB_OUT_RST;
      pb_oe_q    <= PB_DDR_RST;
      pol_q      <= 1'b0;
      pa7_ie_q   <= 1'b0;
      tim_ie_q   <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      last_q     <= 1'b0;
      pa7_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      pa_o_q     <= pa_o_d;
      pa_oe_q    <= pa_oe_d;
      pb_o_q     <= pb_o_d;
      pb_oe_q    <= pb_oe_d;
      pol_q      <= pol_d;
      pa7_ie_q   <= pa7_ie_d;
      tim_ie_q   <= tim_ie_d;
      sync1_q    <= pa_mix[7];
      sync2_q    <= sync1_q;
      last_q     <= sync2_q;
      pa7_flag_q <= pa7_flag_d;
      irq_q      <= irq_d;
    end
  end

  riot_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tim_load),
    .load_val_i (dat_i),
    .sel_i      (adr[1:0]),
    .rd_clr_i   (tim_rd_clr),
    .intim_o    (intim),
    .flag_o     (tim_flag)
  );

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign pa_o  = pa_o_q;
  assign pa_oe = pa_oe_q;
  assign pb_o  = pb_o_q;
  assign pb_oe = pb_oe_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_riot_gen2.sv
// Directed bench for riot_gen2: ports, timer intervals/underflow, PA7 edge
// interrupt and same-cycle collisions, with hand-computed expectations.
module tb_riot_gen2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic       we = 1'b0;
  logic [6:0] adr = 7'h00;
  logic [7:0] wdat = 8'h00;
  logic       ack_o;
  logic [7:0] dat_o;
  logic [7:0] pa_i = 8'hA5;
  logic [7:0] pb_i = 8'h3C;
  logic [7:0] pa_o, pa_oe, pb_o, pb_oe;
  logic       irq_o;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  riot_gen2 #(
    .CLK_DIV    (24),
    .PA_DDR_RST (8'h00),
    .PB_DDR_RST (8'h00),
    .PB_OUT_RST (8'h00)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .stb_i (stb),
    .we_i  (we),
    .adr_i (adr),
    .dat_i (wdat),
    .ack_o (ack_o),
    .dat_o (dat_o),
    .pa_i  (pa_i),
    .pa_o  (pa_o),
    .pa_oe (pa_oe),
    .pb_i  (pb_i),
    .pb_o  (pb_o),
    .pb_oe (pb_oe),
    .irq_o (irq_o)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached at cycle %0d", cyc);
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  // Driver tasks: strobe is high for exactly one rising edge; e is that edge's index.
  task automatic bus_write(input logic [6:0] a, input logic [7:0] d, output int e);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = a; wdat = d;
    @(posedge clk); #1;
    e = cyc;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] a, output logic [7:0] d, output logic ack);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = a;
    @(posedge clk); #1;
    d = dat_o; ack = ack_o;
    stb = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic       ak;
    logic [7:0] exp_rd [6];
    exp_rd = '{8'hA5, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00};
    repeat (3) @(posedge clk);
    @(negedge clk);
    stb = 1'b1; adr = 7'h04;
    @(posedge clk); #1;
    n_vec++; if (ack_o !== 1'b0) begin $display("FAIL rst_ack got %b want 0", ack_o); n_bad++; end
    n_vec++; if (dat_o !== 8'h00) begin $display("FAIL rst_dat got %h want 00", dat_o); n_bad++; end
    n_vec++; if (irq_o !== 1'b0) begin $display("FAIL rst_irq got %b want 0", irq_o); n_bad++; end
    n_vec++; if ({pa_o, pa_oe, pb_o, pb_oe} !== 32'h0) begin
      $display("FAIL rst_ports got %h want 00000000", {pa_o, pa_oe, pb_o, pb_oe}); n_bad++;
    end
    @(negedge clk);
    stb = 1'b0; rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_read(7'(i), rd, ak);
      n_vec++; if (ak !== 1'b1) begin $display("FAIL rd_ack[%0d] got %b want 1", i, ak); n_bad++; end
      n_vec++; if (rd !== exp_rd[i]) begin $display("FAIL rd_reset[%0d] got %h want %h", i, rd, exp_rd[i]); n_bad++; end
    end
    @(posedge clk); #1;
    n_vec++; if (ack_o !== 1'b0) begin $display("FAIL ack_drop got %b want 0", ack_o); n_bad++; end
  endtask

  task automatic test_ports();
    logic [7:0] rd;
    logic       ak;
    int         e;
    bus_write(7'h01, 8'hF0, e);
    bus_write(7'h00, 8'h5A, e);
    pa_i = 8'h0F;
    bus_read(7'h00, rd, ak);
    n_vec++; if (rd !== 8'h5F) begin $display("FAIL swcha got %h want 5F", rd); n_bad++; end
    bus_read(7'h40, rd, ak);
    n_vec++; if (rd !== 8'h5F) begin $display("FAIL swcha_hi_adr got %h want 5F", rd); n_bad++; end
    bus_read(7'h01, rd, ak);
    n_vec++; if (rd !== 8'hF0) begin $display("FAIL swacnt got %h want F0", rd); n_bad++; end
    n_vec++; if ({pa_o, pa_oe} !== 16'h5AF0) begin $display("FAIL pa_pins got %h want 5AF0", {pa_o, pa_oe}); n_bad++; end
    bus_write(7'h03, 8'h0F, e);
    bus_write(7'h02, 8'hA5, e);
    bus_read(7'h02, rd, ak);
    n_vec++; if (rd !== 8'h35) begin $display("FAIL swchb got %h want 35", rd); n_bad++; end
    n_vec++; if ({pb_o, pb_oe} !== 16'hA50F) begin $display("FAIL pb_pins got %h want A50F", {pb_o, pb_oe}); n_bad++; end
    // Enabling PA7 as an output at level 0 was a falling edge on effective PA7.
    bus_read(7'h05, rd, ak);
    n_vec++; if ((rd & 8'h40) !== 8'h40) begin $display("FAIL pa7_fall got %h want bit6 set", rd); n_bad++; end
    bus_read(7'h0D, rd, ak);
    n_vec++; if ((rd & 8'h40) !== 8'h00) begin $display("FAIL pa7_clr got %h want bit6 clear", rd); n_bad++; end
  endtask

  task automatic test_tim8t();
    logic [7:0] rd;
    logic       ak;
    int         w;
    bus_write(7'h15, 8'h03, w);
    for (int k = 0; k < 4; k++) begin
      wait_until(w + 192 * k + 9);
      bus_read(7'h04, rd, ak);
      n_vec++; if (rd !== 8'(3 - k)) begin $display("FAIL tim8t_step%0d got %h want %h", k, rd, 8'(3 - k)); n_bad++; end
    end
    wait_until(w + 768 + 4);
    bus_read(7'h05, rd, ak);
    n_vec++; if (rd !== 8'h80) begin $display("FAIL tim8t_instat got %h want 80", rd); n_bad++; end
    wait_until(w + 768 + 9);
    bus_read(7'h0C, rd, ak);
    n_vec++; if (rd !== 8'hFF) begin $display("FAIL tim8t_wrap got %h want FF", rd); n_bad++; end
    wait_until(w + 792 + 9);
    bus_read(7'h04, rd, ak);
    n_vec++; if (rd !== 8'hFE) begin $display("FAIL tim8t_1t got %h want FE", rd); n_bad++; end
    n_vec++; if (irq_o !== 1'b0) begin $display("FAIL tim8t_irq got %b want 0", irq_o); n_bad++; end
  endtask

  task automatic test_tim64t_irq();
    logic [7:0] rd;
    logic       ak;
    int         w;
    bus_write(7'h1E, 8'h00, w);
    wait_until(w + 1530);
    n_vec++; if (irq_o !== 1'b0) begin $display("FAIL t64_irq_early got %b want 0", irq_o); n_bad++; end
    wait_until(w + 1539);
    n_vec++; if (irq_o !== 1'b1) begin $display("FAIL t64_irq got %b want 1", irq_o); n_bad++; end
    wait_until(w + 1544);
    bus_read(7'h04, rd, ak);
    n_vec++; if (rd !== 8'hFF) begin $display("FAIL t64_wrap got %h want FF", rd); n_bad++; end
    @(posedge clk); #1;
    n_vec++; if (irq_o !== 1'b0) begin $display("FAIL t64_irq_clr got %b want 0", irq_o); n_bad++; end
    wait_until(w + 1560 + 4);
    bus_read(7'h04, rd, ak);
    n_vec++; if (rd !== 8'hFE) begin $display("FAIL t64_1t_a got %h want FE", rd); n_bad++; end
    wait_until(w + 1584 + 4);
    bus_read(7'h04, rd, ak);
    n_vec++; if (rd !== 8'hFD) begin $display("FAIL t64_1t_b got %h want FD", rd); n_bad++; end
  endtask

  task automatic test_pa7();
    logic [7:0] rd;
    logic       ak;
    int         e;
    bus_write(7'h01, 8'h00, e);
    bus_write(7'h07, 8'h00, e);
    bus_read(7'h05, rd, ak);
    n_vec++; if (rd !== 8'h00) begin $display("FAIL pa7_idle got %h want 00", rd); n_bad++; end
    @(negedge clk);
    pa_i = 8'h8F;
    repeat (4) @(posedge clk);
    #1;
    n_vec++; if (irq_o !== 1'b1) begin $display("FAIL pa7_irq got %b want 1", irq_o); n_bad++; end
    bus_read(7'h05, rd, ak);
    n_vec++; if (rd !== 8'h40) begin $display("FAIL pa7_instat got %h want 40", rd); n_bad++; end
    bus_read(7'h05, rd, ak);
    n_vec++; if (rd !== 8'h00) begin $display("FAIL pa7_instat2 got %h want 00", rd); n_bad++; end
    n_vec++; if (irq_o !== 1'b0) begin $display("FAIL pa7_irq_clr got %b want 0", irq_o); n_bad++; end
    @(negedge clk);
    pa_i = 8'h0F;
    repeat (6) @(posedge clk);
    bus_read(7'h05, rd, ak);
    n_vec++; if (rd !== 8'h00) begin $display("FAIL pa7_fall_ignored got %h want 00", rd); n_bad++; end
    n_vec++; if (irq_o !== 1'b0) begin $display("FAIL pa7_fall_irq got %b want 0", irq_o); n_bad++; end
  endtask

  task automatic test_collisions();
    logic [7:0] rd;
    logic       ak;
    int         w, e;
    // Reload mid-period restarts the prescaler.
    bus_write(7'h14, 8'h05, w);
    wait_until(w + 9);
    bus_write(7'h14, 8'h05, e);
    wait_until(e + 19);
    bus_read(7'h04, rd, ak);
    n_vec++; if (rd !== 8'h05) begin $display("FAIL presc_restart got %h want 05", rd); n_bad++; end
    wait_until(e + 26);
    bus_read(7'h04, rd, ak);
    n_vec++; if (rd !== 8'h04) begin $display("FAIL presc_next got %h want 04", rd); n_bad++; end
    // Load on the exact edge of a scheduled decrement.
    bus_write(7'h14, 8'h0A, w);
    wait_until(w + 23);
    bus_write(7'h14, 8'h05, e);
    wait_until(w + 33);
    bus_read(7'h04, rd, ak);
    n_vec++; if (rd !== 8'h05) begin $display("FAIL load_vs_dec got %h want 05", rd); n_bad++; end
    wait_until(w + 48);
    bus_read(7'h04, rd, ak);
    n_vec++; if (rd !== 8'h04) begin $display("FAIL load_vs_dec_next got %h want 04", rd); n_bad++; end
    // Load on the exact edge of an underflow leaves the flag clear.
    bus_write(7'h14, 8'h00, w);
    wait_until(w + 23);
    bus_write(7'h14, 8'h07, e);
    wait_until(w + 29);
    bus_read(7'h05, rd, ak);
    n_vec++; if (rd !== 8'h00) begin $display("FAIL load_vs_uflow_flag got %h want 00", rd); n_bad++; end
    bus_read(7'h04, rd, ak);
    n_vec++; if (rd !== 8'h07) begin $display("FAIL load_vs_uflow_val got %h want 07", rd); n_bad++; end
    // INTIM read-clear on the underflow edge loses to the flag set.
    bus_write(7'h14, 8'h00, w);
    wait_until(w + 23);
    bus_read(7'h04, rd, ak);
    n_vec++; if (rd !== 8'h00) begin $display("FAIL rdclr_vs_uflow_val got %h want 00", rd); n_bad++; end
    wait_until(w + 29);
    bus_read(7'h05, rd, ak);
    n_vec++; if (rd !== 8'h80) begin $display("FAIL rdclr_vs_uflow_flag got %h want 80", rd); n_bad++; end
    bus_read(7'h04, rd, ak);
    n_vec++; if (rd !== 8'hFF) begin $display("FAIL rdclr_vs_uflow_wrap got %h want FF", rd); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_ports();
    test_tim8t();
    test_tim64t_irq();
    test_pa7();
    test_collisions();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
